// File: rtl/icache_axi_rd_bridge_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | icache_axi_rd_bridge_pkg                                              |
// | Shared AXI4 read-channel codes and defaults for the icache bridge.    |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package icache_axi_rd_bridge_pkg;

  localparam int          c_data_w       = 64;

  localparam logic [1:0]  c_resp_okay    = 2'b00;
  localparam logic [1:0]  c_resp_exokay  = 2'b01;
  localparam logic [1:0]  c_resp_slverr  = 2'b10;
  localparam logic [1:0]  c_resp_decerr  = 2'b11;

  localparam logic [1:0]  c_burst_incr   = 2'b01;
  localparam logic [2:0]  c_size_8b      = 3'b011;
  localparam logic [7:0]  c_len_single   = 8'd0;
  localparam logic [2:0]  c_arprot_dflt  = 3'b100;
  localparam logic [3:0]  c_arcache_dflt = 4'b0010;

  // Only a plain OKAY is acceptable for an instruction refill.
  function automatic logic resp_is_bad(input logic [1:0] resp);
    return resp != c_resp_okay;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_axi_rd_bridge_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | icache_axi_rd_bridge_if                                               |
// | AXI4 AR/R channel bundle between the icache bridge and interconnect.  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
interface icache_axi_rd_bridge_if
  import icache_axi_rd_bridge_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 64
);

  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [ID_W-1:0]     arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [2:0]          arprot;
  logic [3:0]          arcache;

  logic                rvalid;
  logic                rready;
  logic [c_data_w-1:0] rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [ID_W-1:0]     rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, arprot, arcache, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, arprot, arcache, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

endinterface
`default_nettype wire

// File: rtl/icache_axi_rd_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | icache_axi_rd_bridge                                                  |
// | Turns each icache refill request into one single-beat AXI4 read.      |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module icache_axi_rd_bridge
  import icache_axi_rd_bridge_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0,
  parameter int ADDR_W = 64
)(
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                cache_read_ena,
  input  wire logic [ADDR_W-1:0]   cache_addr,
  output logic      [c_data_w-1:0] cache_in_data,
  output logic                     cache_in_valid,
  input  wire logic                cache_read_resp,
  output logic                     rd_err,
  icache_axi_rd_bridge_if.master   axi
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_AR   = 4'b0010,
    S_R    = 4'b0100,
    S_RESP = 4'b1000
  } state_t;

  localparam logic [ID_W-1:0] c_axi_id = ID_W'(AXI_ID);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_araddr;
  logic [c_data_w-1:0] r_data;
  logic                r_err;
  logic                r_got_beat;
  logic                r_rd_err;

  logic                w_start;
  logic                w_beat;
  logic                w_beat_bad;
  logic                w_err_acc;
  logic                w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^cache_addr[2:0];

  assign w_start    = (r_state == S_IDLE) && cache_read_ena;
  assign w_beat     = (r_state == S_R) && axi.rvalid;
  // A first beat without rlast means the slave ignored arlen=0.
  assign w_beat_bad = resp_is_bad(axi.rresp) || (axi.rid != c_axi_id) ||
                      (!r_got_beat && !axi.rlast);
  assign w_err_acc  = r_err || w_beat_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cache_read_ena)        w_state_nxt = S_AR;
      S_AR:    if (axi.arready)           w_state_nxt = S_R;
      S_R:     if (w_beat && axi.rlast)   w_state_nxt = S_RESP;
      S_RESP:  if (cache_read_resp)       w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_araddr   <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_got_beat <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_err <= 1'b0;
      if (w_start) begin
        r_araddr   <= {cache_addr[ADDR_W-1:3], 3'b000};
        r_err      <= 1'b0;
        r_got_beat <= 1'b0;
      end
      if (w_beat) begin
        r_err      <= w_err_acc;
        r_got_beat <= 1'b1;
        if (!r_got_beat) begin
          r_data <= axi.rdata;
        end
        // Registered so the pulse lands in the first RESP cycle.
        if (axi.rlast) begin
          r_rd_err <= w_err_acc;
        end
      end
    end
  end

  assign axi.arvalid  = (r_state == S_AR);
  assign axi.araddr   = r_araddr;
  assign axi.arid     = c_axi_id;
  assign axi.arlen    = c_len_single;
  assign axi.arsize   = c_size_8b;
  assign axi.arburst  = c_burst_incr;
  assign axi.arprot   = c_arprot_dflt;
  assign axi.arcache  = c_arcache_dflt;
  assign axi.rready   = (r_state == S_R);

  assign cache_in_valid = (r_state == S_RESP);
  assign cache_in_data  = r_data;
  assign rd_err         = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_icache_axi_rd_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_icache_axi_rd_bridge                                               |
// | Scoreboard bench for the icache AXI4 refill bridge.                   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_icache_axi_rd_bridge;
  import icache_axi_rd_bridge_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_read_ena;
  logic [63:0] cache_addr;
  logic [63:0] cache_in_data;
  logic        cache_in_valid;
  logic        cache_read_resp;
  logic        rd_err;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  icache_axi_rd_bridge_if #(.ID_W(4), .ADDR_W(64)) axi ();

  icache_axi_rd_bridge #(.ID_W(4), .AXI_ID(0), .ADDR_W(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .cache_read_ena  (cache_read_ena),
    .cache_addr      (cache_addr),
    .cache_in_data   (cache_in_data),
    .cache_in_valid  (cache_in_valid),
    .cache_read_resp (cache_read_resp),
    .rd_err          (rd_err),
    .axi             (axi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] d, input logic err);
    exp_t e;
    e.data = d;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Interconnect model: AR stall of ar_wait cycles, R stall of r_wait cycles, then nbeats beats.
  task automatic axi_slave(input int ar_wait, input int r_wait, input logic [63:0] d0,
                           input logic [63:0] d1, input int nbeats, input logic [1:0] resp,
                           input logic [3:0] id, output int t_ar, output logic [63:0] ar_addr,
                           output logic [23:0] ar_attr, output int ar_cycles,
                           output logic ar_stable, output logic rready_ok, output logic timeout);
    int n;
    timeout = 1'b0; ar_stable = 1'b1; rready_ok = 1'b1; ar_cycles = 0; t_ar = -1;
    ar_addr = '0; ar_attr = '0;
    n = 0;
    while (axi.arvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (axi.arvalid !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    t_ar      = cyc;
    ar_addr   = axi.araddr;
    ar_attr   = {axi.arlen, axi.arsize, axi.arburst, axi.arprot, axi.arcache, axi.arid};
    ar_cycles = 1;
    for (int i = 0; i < ar_wait; i++) begin
      axi.arready = 1'b0;
      tick();
      if (axi.arvalid !== 1'b1 || axi.araddr !== ar_addr) ar_stable = 1'b0;
      else ar_cycles++;
    end
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    if (axi.arvalid !== 1'b0) ar_stable = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      if (axi.rready !== 1'b1) rready_ok = 1'b0;
      tick();
    end
    for (int b = 0; b < nbeats; b++) begin
      if (axi.rready !== 1'b1) rready_ok = 1'b0;
      axi.rvalid = 1'b1;
      axi.rdata  = (b == 0) ? d0 : d1;
      axi.rlast  = (b == nbeats - 1);
      axi.rresp  = resp;
      axi.rid    = id;
      tick();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = c_resp_okay;
    axi.rid    = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cache_read_ena = 1'b0; cache_addr = '0; cache_read_resp = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
    axi.rresp = c_resp_okay; axi.rlast = 1'b0; axi.rid = 4'd0;
    tick(); tick();
    vectors++;
    if ({axi.arvalid, axi.rready, cache_in_valid, rd_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: {arvalid,rready,valid,rd_err}=%b, required 0000",
               {axi.arvalid, axi.rready, cache_in_valid, rd_err});
    end
    vectors++;
    if (cache_in_data !== 64'd0 || axi.araddr !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_regs: data=%h araddr=%h, required both 0", cache_in_data, axi.araddr);
    end
    rst = 1'b1;
    tick();
    axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 64'hFFFF;
    tick();
    vectors++;
    if (axi.rready !== 1'b0 || cache_in_valid !== 1'b0 || cache_in_data !== 64'd0) begin
      miscompares++;
      $display("FAIL stray_rvalid: rready=%b valid=%b data=%h, required 0/0/0",
               axi.rready, cache_in_valid, cache_in_data);
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0;
  endtask

  task automatic test_single();
    int t0, t_ar, arc; logic [63:0] a; logic [23:0] attr; logic st, rok, to; exp_t e;
    push_exp(64'hDEAD_BEEF_0000_1111, 1'b0);
    cache_addr = 64'h8000_0014; cache_read_ena = 1'b1; t0 = cyc;
    axi_slave(0, 0, 64'hDEAD_BEEF_0000_1111, 64'd0, 1, c_resp_okay, 4'd0,
              t_ar, a, attr, arc, st, rok, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL single_timeout: arvalid never rose"); end
    vectors++;
    if (t_ar - t0 !== 1) begin miscompares++; $display("FAIL single_ar_lat: got %0d, required 1", t_ar - t0); end
    vectors++;
    if (a !== 64'h8000_0010) begin miscompares++; $display("FAIL single_araddr: got %h, required 0000000080000010", a); end
    vectors++;
    if (attr !== {8'd0, 3'b011, 2'b01, 3'b100, 4'b0010, 4'd0}) begin
      miscompares++; $display("FAIL single_ar_attr: got %h, required %h", attr,
                              {8'd0, 3'b011, 2'b01, 3'b100, 4'b0010, 4'd0});
    end
    vectors++;
    if (cyc - t0 !== 3) begin miscompares++; $display("FAIL single_valid_lat: got %0d, required 3", cyc - t0); end
    vectors++;
    if (cache_in_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL single_deliver: valid=%b queued=%0d, required 1 with entry", cache_in_valid, sb.size());
    end else begin
      e = sb.pop_front();
      vectors++;
      if (cache_in_data !== e.data) begin miscompares++; $display("FAIL single_data: got %h, required %h", cache_in_data, e.data); end
      vectors++;
      if (rd_err !== e.err) begin miscompares++; $display("FAIL single_rd_err: got %b, required %b", rd_err, e.err); end
    end
    tick(); tick();
    vectors++;
    if (cache_in_valid !== 1'b1 || cache_in_data !== 64'hDEAD_BEEF_0000_1111 || rd_err !== 1'b0) begin
      miscompares++; $display("FAIL single_hold: valid=%b data=%h rd_err=%b, required 1/deadbeef00001111/0",
                              cache_in_valid, cache_in_data, rd_err);
    end
    cache_read_resp = 1'b1; cache_read_ena = 1'b0;
    tick();
    cache_read_resp = 1'b0;
    vectors++;
    if (cache_in_valid !== 1'b0) begin miscompares++; $display("FAIL single_close: valid=%b, required 0", cache_in_valid); end
  endtask

  task automatic test_backpressure();
    int t0, t_ar, arc; logic [63:0] a; logic [23:0] attr; logic st, rok, to; exp_t e;
    int rises;
    push_exp(64'h0123_4567_89AB_CDEF, 1'b0);
    cache_addr = 64'h0000_0000_0000_4008; cache_read_ena = 1'b1; t0 = cyc;
    axi_slave(5, 7, 64'h0123_4567_89AB_CDEF, 64'd0, 1, c_resp_okay, 4'd0,
              t_ar, a, attr, arc, st, rok, to);
    vectors++;
    if (to !== 1'b0 || arc !== 6 || st !== 1'b1) begin
      miscompares++; $display("FAIL bp_ar_hold: timeout=%b cycles=%0d stable=%b, required 0/6/1", to, arc, st);
    end
    vectors++;
    if (rok !== 1'b1) begin miscompares++; $display("FAIL bp_rready: rready dropped in R, required held"); end
    vectors++;
    if (cyc - t0 !== 15) begin miscompares++; $display("FAIL bp_latency: got %0d, required 15", cyc - t0); end
    vectors++;
    if (cache_in_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL bp_deliver: valid=%b queued=%0d, required 1 with entry", cache_in_valid, sb.size());
    end else begin
      e = sb.pop_front();
      vectors++;
      if (cache_in_data !== e.data || rd_err !== e.err) begin
        miscompares++; $display("FAIL bp_data: got %h/%b, required %h/%b", cache_in_data, rd_err, e.data, e.err);
      end
    end
    cache_read_resp = 1'b1; cache_read_ena = 1'b0;
    tick();
    cache_read_resp = 1'b0;
    rises = 0;
    for (int i = 0; i < 4; i++) begin
      if (cache_in_valid === 1'b1) rises++;
      tick();
    end
    vectors++;
    if (rises !== 0) begin miscompares++; $display("FAIL bp_once: extra valid cycles=%0d, required 0", rises); end
  endtask

  task automatic test_error();
    int t_ar, arc; logic [63:0] a; logic [23:0] attr; logic st, rok, to; exp_t e;
    push_exp(64'h1234, 1'b1);
    cache_addr = 64'h100; cache_read_ena = 1'b1;
    axi_slave(0, 1, 64'h1234, 64'd0, 1, c_resp_slverr, 4'd0, t_ar, a, attr, arc, st, rok, to);
    vectors++;
    if (to !== 1'b0 || cache_in_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL err_deliver: timeout=%b valid=%b, required 0/1", to, cache_in_valid);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (cache_in_data !== e.data || rd_err !== e.err) begin
        miscompares++; $display("FAIL err_slverr: got %h/%b, required %h/%b", cache_in_data, rd_err, e.data, e.err);
      end
    end
    tick();
    vectors++;
    if (rd_err !== 1'b0 || cache_in_valid !== 1'b1) begin
      miscompares++; $display("FAIL err_pulse: rd_err=%b valid=%b one cycle later, required 0/1", rd_err, cache_in_valid);
    end
    cache_read_resp = 1'b1; cache_read_ena = 1'b0;
    tick();
    cache_read_resp = 1'b0;
    tick();
    vectors++;
    if (cache_in_valid !== 1'b0 || axi.arvalid !== 1'b0 || axi.rready !== 1'b0) begin
      miscompares++; $display("FAIL err_idle: valid=%b arvalid=%b rready=%b, required 000",
                              cache_in_valid, axi.arvalid, axi.rready);
    end
    // Wrong rid with an OKAY response is still an error.
    push_exp(64'hA5A5, 1'b1);
    cache_addr = 64'h200; cache_read_ena = 1'b1;
    axi_slave(0, 0, 64'hA5A5, 64'd0, 1, c_resp_okay, 4'd5, t_ar, a, attr, arc, st, rok, to);
    vectors++;
    if (to !== 1'b0 || cache_in_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL rid_deliver: timeout=%b valid=%b, required 0/1", to, cache_in_valid);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (cache_in_data !== e.data || rd_err !== e.err) begin
        miscompares++; $display("FAIL rid_err: got %h/%b, required %h/%b", cache_in_data, rd_err, e.data, e.err);
      end
    end
    cache_read_resp = 1'b1; cache_read_ena = 1'b0;
    tick();
    cache_read_resp = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t_ar, arc, stable; logic [63:0] a; logic [23:0] attr; logic st, rok, to; exp_t e;
    push_exp(64'h5555_AAAA_5555_AAAA, 1'b0);
    cache_addr = 64'h1000; cache_read_ena = 1'b1;
    axi_slave(0, 0, 64'h5555_AAAA_5555_AAAA, 64'd0, 1, c_resp_okay, 4'd0, t_ar, a, attr, arc, st, rok, to);
    vectors++;
    if (to !== 1'b0 || cache_in_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL stall_deliver: timeout=%b valid=%b, required 0/1", to, cache_in_valid);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (cache_in_data !== e.data || rd_err !== e.err) begin
        miscompares++; $display("FAIL stall_data: got %h/%b, required %h/%b", cache_in_data, rd_err, e.data, e.err);
      end
    end
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      cache_addr = {32'd0, $urandom} & 64'hFFFF_FFF8;
      tick();
      if (cache_in_valid === 1'b1 && cache_in_data === 64'h5555_AAAA_5555_AAAA &&
          axi.araddr === 64'h1000 && axi.arvalid === 1'b0) stable++;
    end
    vectors++;
    if (stable !== 10) begin miscompares++; $display("FAIL stall_hold: stable cycles=%0d, required 10", stable); end
    // Resp and a still-high request coincide: only the resp acts this cycle.
    cache_read_resp = 1'b1; cache_addr = 64'h200F;
    tick();
    cache_read_resp = 1'b0;
    vectors++;
    if (cache_in_valid !== 1'b0 || axi.arvalid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_gap: valid=%b arvalid=%b in gap cycle, required 0/0", cache_in_valid, axi.arvalid);
    end
    push_exp(64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    tick();
    vectors++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== 64'h2008) begin
      miscompares++; $display("FAIL b2b_restart: arvalid=%b araddr=%h, required 1/0000000000002008", axi.arvalid, axi.araddr);
    end
    axi_slave(0, 0, 64'h0F0F_0F0F_0F0F_0F0F, 64'd0, 1, c_resp_okay, 4'd0, t_ar, a, attr, arc, st, rok, to);
    vectors++;
    if (to !== 1'b0 || cache_in_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL b2b_deliver: timeout=%b valid=%b, required 0/1", to, cache_in_valid);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (cache_in_data !== e.data || rd_err !== e.err) begin
        miscompares++; $display("FAIL b2b_data: got %h/%b, required %h/%b", cache_in_data, rd_err, e.data, e.err);
      end
    end
    cache_read_resp = 1'b1; cache_read_ena = 1'b0;
    tick();
    cache_read_resp = 1'b0;
  endtask

  task automatic test_multibeat();
    int t_ar, arc; logic [63:0] a; logic [23:0] attr; logic st, rok, to; exp_t e;
    push_exp(64'hAAAA_0000_AAAA_0000, 1'b1);
    cache_addr = 64'h3010; cache_read_ena = 1'b1;
    axi_slave(1, 0, 64'hAAAA_0000_AAAA_0000, 64'hBBBB_1111_BBBB_1111, 2, c_resp_okay, 4'd0,
              t_ar, a, attr, arc, st, rok, to);
    vectors++;
    if (to !== 1'b0 || cache_in_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL multi_deliver: timeout=%b valid=%b, required 0/1", to, cache_in_valid);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (cache_in_data !== e.data || rd_err !== e.err) begin
        miscompares++; $display("FAIL multi_beat: got %h/%b, required %h/%b", cache_in_data, rd_err, e.data, e.err);
      end
    end
    cache_read_resp = 1'b1; cache_read_ena = 1'b0;
    tick();
    cache_read_resp = 1'b0;
  endtask

  task automatic test_async_reset();
    int t0, t_ar, arc, n; logic [63:0] a; logic [23:0] attr; logic st, rok, to; exp_t e;
    cache_addr = 64'h7000; cache_read_ena = 1'b1;
    n = 0;
    while (axi.arvalid !== 1'b1 && n < 20) begin tick(); n++; end
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    vectors++;
    if (axi.rready !== 1'b1) begin miscompares++; $display("FAIL areset_in_r: rready=%b, required 1", axi.rready); end
    cache_read_ena = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({axi.arvalid, axi.rready, cache_in_valid} !== 3'b000 || axi.araddr !== 64'd0) begin
      miscompares++; $display("FAIL areset_now: {arvalid,rready,valid}=%b araddr=%h, required 000/0",
                              {axi.arvalid, axi.rready, cache_in_valid}, axi.araddr);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    push_exp(64'hCAFE_F00D_CAFE_F00D, 1'b0);
    cache_addr = 64'h9018; cache_read_ena = 1'b1; t0 = cyc;
    axi_slave(0, 0, 64'hCAFE_F00D_CAFE_F00D, 64'd0, 1, c_resp_okay, 4'd0, t_ar, a, attr, arc, st, rok, to);
    vectors++;
    if (to !== 1'b0 || t_ar - t0 !== 1 || a !== 64'h9018) begin
      miscompares++; $display("FAIL areset_restart: timeout=%b lat=%0d araddr=%h, required 0/1/0000000000009018",
                              to, t_ar - t0, a);
    end
    vectors++;
    if (cache_in_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL areset_deliver: valid=%b, required 1", cache_in_valid);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (cache_in_data !== e.data || rd_err !== e.err) begin
        miscompares++; $display("FAIL areset_data: got %h/%b, required %h/%b", cache_in_data, rd_err, e.data, e.err);
      end
    end
    cache_read_resp = 1'b1; cache_read_ena = 1'b0;
    tick();
    cache_read_resp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_error();
    test_back_to_back();
    test_multibeat();
    test_async_reset();
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++; $display("FAIL sb_drain: %0d expected entries never delivered, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- AXI4 read master that serves the i_cache miss-refill port (cache_read_ena/cache_addr → cache_in_data/cache_in_valid, closed by cache_read_resp).
- Converts each refill request into one single-beat 64-bit AXI4 read transaction.
- Sits between i_cache and the AXI4 interconnect/arbiter; it is the only agent that drives the icache AR/R channels.

Parameters:
- ID_W, 4, width of arid/rid.
- AXI_ID, 0, constant ID driven on arid; rid is checked against it.
- ADDR_W, 64, address width of cache_addr and araddr.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cache_read_ena  in  1  refill request, level; held by the cache until data is returned.
- cache_addr  in  ADDR_W  refill address; bits [2:0] are ignored and forced to 0.
- cache_in_data  out  64  refill data to the cache.
- cache_in_valid  out  1  refill data valid; held high until cache_read_resp.
- cache_read_resp  in  1  cache has consumed cache_in_data.
- rd_err  out  1  one-cycle pulse in the RESP-entry cycle on a bad response.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- araddr  out  ADDR_W  AR address.
- arid  out  ID_W  AR ID.
- arlen  out  8  burst length; constant 0.
- arsize  out  3  beat size; constant 3'b011.
- arburst  out  2  burst type; constant INCR.
- arprot  out  3  constant 3'b100 (instruction access).
- arcache  out  4  constant 4'b0010.
- rvalid  in  1  R valid.
- rready  out  1  R ready.
- rdata  in  64  R data.
- rresp  in  2  R response.
- rlast  in  1  R last beat.
- rid  in  ID_W  R ID.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - arvalid, rready, cache_in_valid, rd_err are 0.
  - cache_in_data and araddr are 0.
  - Reset mid-transaction abandons the transfer; the interconnect is reset on the same rst.
- States: IDLE, AR, R, RESP, one-hot, 4 bits.
- IDLE:
  - If cache_read_ena=1, latch {cache_addr[ADDR_W-1:3],3'b0} into araddr, clear the error flag, go to AR.
  - If cache_read_ena=0, stay in IDLE.
  - The request is sampled only in IDLE; cache_addr changes outside IDLE are ignored.
- AR:
  - arvalid=1 and araddr stable.
  - If arready=1 in a cycle, arvalid drops the next cycle and the state goes to R.
  - arvalid is never withdrawn before arready.
- R:
  - rready=1.
  - On the first rvalid&rready, capture rdata into cache_in_data.
  - Set the error flag if rresp!=OKAY or rid!=AXI_ID.
  - When rvalid&rready&rlast, go to RESP.
  - If the first beat arrives without rlast, set the error flag, keep the first beat's data, and keep accepting beats until rlast.
- RESP:
  - cache_in_valid=1; cache_in_data is held.
  - rd_err pulses high in the entry cycle if the error flag is set.
  - When cache_read_resp=1, go to IDLE. cache_in_valid drops the next cycle.
  - cache_read_ena is ignored while in RESP.
- Latency with arready and rvalid both 1 on first opportunity:
  - req in IDLE at cycle 0 → arvalid at cycle 1.
  - rready at cycle 2.
  - cache_in_valid at cycle 3.
- Back-to-back requests:
  - After RESP→IDLE, a cache_read_ena still high in IDLE starts a new transaction.
  - Minimum gap is 1 IDLE cycle.
- Simultaneous cache_read_resp and a new cache_read_ena: only the resp is honoured that cycle.
- At most one outstanding AXI transaction at any time.
- A stray rvalid seen outside R is not accepted, because rready=0.

Decomposition:
- Shared AXI4 package/defines:
  - OKAY/EXOKAY/SLVERR/DECERR codes.
  - BURST_INCR.
  - SIZE_8B.
  - The default ARPROT/ARCACHE constants.
- State encodings are local to this module.
- No sub-module: a single FSM plus the data/error registers is the natural size.

Test Plan:
- Single refill: cache_read_ena=1 with cache_addr=0x8000_0014, arready=1, rvalid next cycle with rdata=0xDEAD_BEEF_0000_1111, rlast=1, OKAY → araddr=0x8000_0010, arlen=0, arsize=3; cache_in_valid high cycle 3 with that data; held until cache_read_resp; rd_err=0.
- Backpressure: arready low 5 cycles, then rvalid delayed 7 cycles → arvalid held stable for 6 cycles, rready held high throughout R, data delivered once.
- Error response: rresp=SLVERR, rdata=0x1234 → cache_in_data=0x1234, rd_err pulses 1 cycle on RESP entry, FSM returns to IDLE after resp.
- Resp stall: cache_read_resp held low 10 cycles → cache_in_valid and cache_in_data stable for 10 cycles; a changing cache_addr does not alter araddr.
- Multi-beat protocol violation: beat 1 with rlast=0 and data A, beat 2 with rlast=1 and data B → cache_in_data=A, rd_err pulses.
- Async reset: assert rst low while in R → arvalid/rready/cache_in_valid go to 0 immediately; after release, a new request starts cleanly from IDLE.
